// File: rtl/minisys_rst_seq_pkg.sv
// Shared types and constants for the minisys reset sequencer.
// Holds the FSM state encodings, the reset-level constants and a small helper.
package minisys_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } rst_state_t;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/minisys_rst_seq_cnt.sv
// rst_seq_cnt: parametrised-width up-counter with sync clear, enable and
// terminal-count flag. Ports: clk, i_clr, i_en, i_lim (terminal value), o_tc.
module rst_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_lim,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Clear wins over enable so a state change always restarts from zero.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == i_lim);

endmodule

// File: rtl/minisys_rst_seq.sv
// minisys_rst_seq: staged reset release with soft restart and optional watchdog.
// Ports: clk, rst (sync, active-high), soft_rst_req, wdt_kick, rst_out[NCH],
// ready, wdt_fired. Macro RST_SEQ_WDT_EN enables the watchdog.
module minisys_rst_seq
    import minisys_rst_seq_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int STAGGER     = 1,
    parameter int WDT_LIMIT   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           soft_rst_req,
    input  logic           wdt_kick,
    output logic [NCH-1:0] rst_out,
    output logic           ready,
    output logic           wdt_fired
);

    localparam int CW = $clog2(imax(HOLD_CYCLES, STAGGER)) + 1;
    localparam int IW = $clog2(NCH) + 1;

    rst_state_t     r_state;
    logic [NCH-1:0] r_rst_out;
    logic           r_ready;
    logic [IW-1:0]  r_idx;

    logic           w_seq_tc;
    logic           w_seq_clr;
    logic [CW-1:0]  w_seq_lim;
    logic           w_wdt_to;
    logic           w_restart;

    assign w_seq_lim = (r_state == ST_HOLD) ? CW'(HOLD_CYCLES - 1)
                                            : CW'(STAGGER - 1);

    // The shared hold/stagger counter restarts on every state change and
    // on each channel release; it is parked at zero outside HOLD/RELEASE.
    assign w_seq_clr = rst | w_restart | w_seq_tc |
                       ((r_state != ST_HOLD) && (r_state != ST_RELEASE));

    rst_seq_cnt #(.W(CW)) u_seq_cnt (
        .clk   (clk),
        .i_clr (w_seq_clr),
        .i_en  (1'b1),
        .i_lim (w_seq_lim),
        .o_tc  (w_seq_tc)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int WW = $clog2(WDT_LIMIT) + 1;

    logic w_wdt_tc;
    logic w_wdt_clr;
    logic r_wdt_fired;

    assign w_wdt_clr = rst | soft_rst_req | wdt_kick | w_wdt_to |
                       (r_state != ST_RUN);

    rst_seq_cnt #(.W(WW)) u_wdt_cnt (
        .clk   (clk),
        .i_clr (w_wdt_clr),
        .i_en  (r_state == ST_RUN),
        .i_lim (WW'(WDT_LIMIT - 1)),
        .o_tc  (w_wdt_tc)
    );

    assign w_wdt_to = (r_state == ST_RUN) && w_wdt_tc && !wdt_kick;

    // Sticky: only the hard reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_fired <= 1'b0;
        end else if (w_wdt_to) begin
            r_wdt_fired <= 1'b1;
        end
    end

    assign wdt_fired = r_wdt_fired;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = wdt_kick ^ WDT_LIMIT[0];
    assign w_wdt_to     = 1'b0;
    assign wdt_fired    = 1'b0;
`endif

    assign w_restart = soft_rst_req | w_wdt_to;

    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_state   <= ST_HOLD;
            r_rst_out <= {NCH{RstEnable}};
            r_ready   <= 1'b0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_seq_tc) begin
                        r_state <= ST_RELEASE;
                        r_idx   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (w_seq_tc) begin
                        // Lower channels are already clear, so dropping
                        // the lowest set bit releases channel r_idx.
                        r_rst_out <= r_rst_out & (r_rst_out - NCH'(1));
                        if (r_idx == IW'(NCH - 1)) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= ST_HOLD;
                    r_rst_out <= {NCH{RstEnable}};
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;

endmodule

// File: tb/tb_minisys_rst_seq.sv
// Directed bench for minisys_rst_seq: two instances (2/1 and 3/2 timing)
// driven in lockstep; watchdog checks follow RST_SEQ_WDT_EN.
module tb_minisys_rst_seq;

    logic       clk;
    logic       rst;
    logic       soft_rst_req;
    logic       wdt_kick;
    logic [3:0] a_out;
    logic       a_rdy;
    logic       a_wdt;
    logic [3:0] b_out;
    logic       b_rdy;
    logic       b_wdt;

    int n_err;
    int n_chk;

    minisys_rst_seq #(
        .NCH(4), .HOLD_CYCLES(2), .STAGGER(1), .WDT_LIMIT(8)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .rst_out      (a_out),
        .ready        (a_rdy),
        .wdt_fired    (a_wdt)
    );

    minisys_rst_seq #(
        .NCH(4), .HOLD_CYCLES(3), .STAGGER(2), .WDT_LIMIT(8)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .rst_out      (b_out),
        .ready        (b_rdy),
        .wdt_fired    (b_wdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel k falls at edge h+(k+1)*s counted from the first free edge.
    function automatic logic [3:0] exp_out(input int e, input int h,
                                           input int s);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (e < h + (k + 1) * s);
        return v;
    endfunction

    task automatic chk_seq(input string tag, input int e);
        chk($sformatf("%s_a_out_e%0d", tag, e), 32'(a_out),
            32'(exp_out(e, 2, 1)));
        chk($sformatf("%s_a_rdy_e%0d", tag, e), 32'(a_rdy),
            32'(e >= 6));
        chk($sformatf("%s_b_out_e%0d", tag, e), 32'(b_out),
            32'(exp_out(e, 3, 2)));
        chk($sformatf("%s_b_rdy_e%0d", tag, e), 32'(b_rdy),
            32'(e >= 11));
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int drops;
        n_err        = 0;
        n_chk        = 0;
        rst          = 1'b1;
        soft_rst_req = 1'b0;
        wdt_kick     = 1'b0;
        step();
        step();
        chk("rst_a_out", 32'(a_out), 32'hf);
        chk("rst_a_rdy", 32'(a_rdy), 32'h0);
        chk("rst_a_wdt", 32'(a_wdt), 32'h0);
        chk("rst_b_out", 32'(b_out), 32'hf);
        rst = 1'b0;

        // Power-on sequence, every edge E1..E12.
        for (int e = 1; e <= 12; e++) begin
            step();
            chk_seq("por", e);
        end

        // Soft restart at E4 while both instances are mid-sequence.
        hard_reset();
        for (int e = 1; e <= 3; e++) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        chk("soft_a_out", 32'(a_out), 32'hf);
        chk("soft_a_rdy", 32'(a_rdy), 32'h0);
        chk("soft_b_out", 32'(b_out), 32'hf);
        for (int n = 1; n <= 12; n++) begin
            step();
            chk_seq("soft", n);
        end

        // rst and soft_rst_req together while running.
        rst          = 1'b1;
        soft_rst_req = 1'b1;
        step();
        rst          = 1'b0;
        soft_rst_req = 1'b0;
        chk("both_a_out", 32'(a_out), 32'hf);
        chk("both_a_rdy", 32'(a_rdy), 32'h0);
        chk("both_a_wdt", 32'(a_wdt), 32'h0);
        chk("both_b_rdy", 32'(b_rdy), 32'h0);

`ifdef RST_SEQ_WDT_EN
        // No kick: A runs from E6, fires on its 8th RUN edge (E14).
        hard_reset();
        for (int e = 1; e <= 19; e++) begin
            step();
            if (e == 13) chk("wdt_a_rdy_e13", 32'(a_rdy), 32'h1);
            if (e == 14) begin
                chk("wdt_a_rdy_e14", 32'(a_rdy), 32'h0);
                chk("wdt_a_out_e14", 32'(a_out), 32'hf);
                chk("wdt_a_wdt_e14", 32'(a_wdt), 32'h1);
            end
            if (e == 17) begin
                chk("wdt_a_out_e17", 32'(a_out), 32'he);
                chk("wdt_a_wdt_e17", 32'(a_wdt), 32'h1);
            end
            if (e == 18) chk("wdt_b_rdy_e18", 32'(b_rdy), 32'h1);
            if (e == 19) begin
                chk("wdt_b_rdy_e19", 32'(b_rdy), 32'h0);
                chk("wdt_b_wdt_e19", 32'(b_wdt), 32'h1);
            end
        end

        // Kick every 4 cycles: no timeout.
        hard_reset();
        for (int e = 1; e <= 12; e++) step();
        drops = 0;
        for (int c = 0; c < 40; c++) begin
            wdt_kick = (c % 4 == 0);
            step();
            if (!a_rdy || !b_rdy) drops++;
        end
        wdt_kick = 1'b0;
        chk("kick_drops", 32'(drops), 32'h0);
        chk("kick_a_wdt", 32'(a_wdt), 32'h0);
        chk("kick_b_wdt", 32'(b_wdt), 32'h0);
`else
        // Watchdog absent: 100 idle RUN cycles change nothing.
        hard_reset();
        for (int e = 1; e <= 12; e++) step();
        drops = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (!a_rdy || !b_rdy || a_wdt || b_wdt) drops++;
        end
        chk("nowdt_drops", 32'(drops), 32'h0);
        chk("nowdt_a_rdy", 32'(a_rdy), 32'h1);
        chk("nowdt_a_wdt", 32'(a_wdt), 32'h0);
        chk("nowdt_b_wdt", 32'(b_wdt), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/minisys_rst_seq.md
MINISYS_RST_SEQ -- requirements
Module: minisys_rst_seq

Interface
REQ-001 Parameter NCH, default 4, number of reset channels (legal 1..16).
REQ-002 Parameter HOLD_CYCLES, default 2, cycles all channels stay asserted after reset release (legal >=1).
REQ-003 Parameter STAGGER, default 1, cycles between successive channel releases (legal >=1).
REQ-004 Parameter WDT_LIMIT, default 1024, watchdog timeout in cycles (legal >=2).
REQ-005 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port soft_rst_req  input  1  single-cycle request to re-run the sequence.
REQ-008 Port wdt_kick  input  1  watchdog heartbeat from the core.
REQ-009 Port rst_out  output  NCH  per-channel reset, active-high, registered.
REQ-010 Port ready  output  1  high when all channels are released, registered.
REQ-011 Port wdt_fired  output  1  sticky watchdog-timeout flag, registered.

Function
REQ-012 The FSM SHALL have exactly three states: HOLD, RELEASE, RUN.
REQ-013 In HOLD, rst_out SHALL be all ones and ready 0; a counter increments each cycle; on the edge sampling count == HOLD_CYCLES-1, the FSM moves to RELEASE with index 0 and stagger count 0.
REQ-014 In RELEASE, a stagger counter SHALL increment each cycle; on the edge sampling count == STAGGER-1, it clears rst_out[index], increments index and zeroes the count.
REQ-015 Channels SHALL release in ascending index order, channel 0 first.
REQ-016 On the edge that clears rst_out[NCH-1], the FSM SHALL enter RUN and ready SHALL rise on the same edge.
REQ-017 Let E1 be the first edge sampling rst=0; rst_out[k] SHALL fall at edge E(HOLD_CYCLES+(k+1)*STAGGER).
REQ-018 soft_rst_req=1 sampled in any state SHALL, on that edge, set rst_out to all ones, drop ready, zero all counters and enter HOLD.
REQ-019 If rst=1 and soft_rst_req=1 are sampled together, rst SHALL take priority.
REQ-020 If soft_rst_req=1 and wdt_kick=1 are sampled together, soft_rst_req SHALL take priority.
REQ-021 Counter widths SHALL be $clog2 of their limit plus 1; counters SHALL never wrap, being cleared on every state change.
REQ-022 wdt_kick SHALL be ignored outside RUN.

Reset
REQ-023 rst=1 sampled SHALL force HOLD, rst_out all ones, ready 0, wdt_fired 0 and all counters 0, regardless of the current state (mid-RELEASE included).
REQ-024 wdt_fired SHALL be cleared only by rst, never by soft_rst_req.

Configuration
REQ-025 Macro RST_SEQ_WDT_EN: when defined, in RUN a watchdog counter SHALL increment each cycle and clear on wdt_kick; on the edge sampling count == WDT_LIMIT-1 without a kick, the block SHALL behave as for soft_rst_req and set wdt_fired to 1.
REQ-026 When RST_SEQ_WDT_EN is undefined, the watchdog logic SHALL be absent, wdt_kick unused and wdt_fired constant 0; the port list SHALL be identical in both builds.

Structure
REQ-027 The state encodings (HOLD=2'b00, RELEASE=2'b01, RUN=2'b10) and RstEnable/RstDisable SHALL live in the shared define header.
REQ-028 One sub-module, rst_seq_cnt, SHALL be used: a parametrised-width up-counter with sync clear, enable and terminal-count output, instantiated for the hold/stagger count and the watchdog count.

Verification
REQ-029 NCH=4, HOLD=2, STAGGER=1, rst high 1 cycle then low -> rst_out[0..3] fall at E3, E4, E5, E6; ready rises at E6.
REQ-030 NCH=4, HOLD=3, STAGGER=2 -> rst_out[k] falls at E(5+2k); ready rises at E11; rst_out is never partially reasserted.
REQ-031 soft_rst_req pulse at E4 during RELEASE -> rst_out=4'b1111 and ready=0 after E4; the full sequence restarts, with rst_out[0] falling 3 edges later.
REQ-032 rst and soft_rst_req both high in RUN -> full reset; wdt_fired=0.
REQ-033 With RST_SEQ_WDT_EN, WDT_LIMIT=8 and no kick in RUN -> the 8th RUN edge re-enters HOLD; wdt_fired=1 persists through the re-sequence; kicking every 4 cycles causes no timeout.
REQ-034 Without RST_SEQ_WDT_EN, 100 cycles in RUN with no kick -> ready stays 1 and wdt_fired stays 0.
